// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcodes, instruction field
// positions and the decoded-control bundle.
package decode_pkg;

    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned FIELD_W    = 4;

    // Instruction field LSB positions: [15:12] op, [11:8] rs1, [7:4] rs2, [3:0] rd/imm/addr
    localparam int unsigned OPCODE_LSB = 12;
    localparam int unsigned RS1_LSB    = 8;
    localparam int unsigned RS2_LSB    = 4;
    localparam int unsigned RD_LSB     = 0;

    localparam logic [FIELD_W-1:0] OP_NOP = 4'h0;
    localparam logic [FIELD_W-1:0] OP_ADD = 4'h1;
    localparam logic [FIELD_W-1:0] OP_SUB = 4'h2;
    localparam logic [FIELD_W-1:0] OP_LDI = 4'h3;
    localparam logic [FIELD_W-1:0] OP_STI = 4'h4;
    localparam logic [FIELD_W-1:0] OP_LD  = 4'h5;
    localparam logic [FIELD_W-1:0] OP_ST  = 4'h7;

    typedef struct packed {
        logic we;
        logic ld;
        logic st;
        logic illegal;
    } ctrl_t;

    function automatic logic [FIELD_W-1:0] get_field(input logic [INSTR_W-1:0] instr,
                                                     input int unsigned lsb);
        return instr[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decoder: splits the instruction into
// operands, destination, memory address and control enables, and reports
// which source registers the instruction actually reads.
module instr_decoder
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned MEM_ADDR_W = 4
) (
    input  logic [INSTR_W-1:0]    instruction,
    input  logic [DATA_W-1:0]     rd1,
    input  logic [DATA_W-1:0]     rd2,
    output logic [FIELD_W-1:0]    opcode,
    output logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  use_rs1,
    output logic                  use_rs2,
    output logic [DATA_W-1:0]     op1,
    output logic [DATA_W-1:0]     op2,
    output logic [REG_ADDR_W-1:0] dest,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  we,
    output logic                  ld,
    output logic                  st,
    output logic                  illegal
);

    logic [FIELD_W-1:0] f_rs1;
    logic [FIELD_W-1:0] f_rs2;
    logic [FIELD_W-1:0] f_rd;
    ctrl_t              ctrl;

    assign opcode   = get_field(instruction, OPCODE_LSB);
    assign f_rs1    = get_field(instruction, RS1_LSB);
    assign f_rs2    = get_field(instruction, RS2_LSB);
    assign f_rd     = get_field(instruction, RD_LSB);
    assign rs1_addr = REG_ADDR_W'(f_rs1);
    assign rs2_addr = REG_ADDR_W'(f_rs2);

    // Per-opcode field selection; everything not named by an opcode stays zero
    always_comb begin
        ctrl     = '0;
        op1      = '0;
        op2      = '0;
        dest     = '0;
        mem_addr = '0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        case (opcode)
            OP_NOP: begin
            end
            OP_ADD, OP_SUB: begin
                op1     = rd1;
                op2     = rd2;
                dest    = REG_ADDR_W'(f_rd);
                ctrl.we = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_LDI: begin
                dest    = REG_ADDR_W'(f_rs1);
                op1     = DATA_W'(f_rd);
                ctrl.we = 1'b1;
            end
            OP_STI: begin
                op1      = DATA_W'(f_rs1);
                mem_addr = MEM_ADDR_W'(f_rd);
                ctrl.st  = 1'b1;
            end
            OP_LD: begin
                dest     = REG_ADDR_W'(f_rs1);
                mem_addr = MEM_ADDR_W'(f_rd);
                ctrl.we  = 1'b1;
                ctrl.ld  = 1'b1;
            end
            OP_ST: begin
                op1      = rd1;
                mem_addr = MEM_ADDR_W'(f_rd);
                ctrl.st  = 1'b1;
                use_rs1  = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

    assign we      = ctrl.we;
    assign ld      = ctrl.ld;
    assign st      = ctrl.st;
    assign illegal = ctrl.illegal;

endmodule

// File: rtl/pipelined_decode_stage.sv
// Decode stage with ID/EX pipeline register, valid/ready handshakes on both
// sides, one-bubble load-use stall, flush and a saturating stall counter.
module pipelined_decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned REG_ADDR_W  = 4,
    parameter int unsigned MEM_ADDR_W  = 4,
    parameter bit          HAZARD_EN   = 1'b1,
    parameter int unsigned STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_W-1:0]     instruction,
    input  logic                   flush,
    output logic [REG_ADDR_W-1:0]  rf_rd_addr1,
    output logic [REG_ADDR_W-1:0]  rf_rd_addr2,
    input  logic [DATA_W-1:0]      rf_rd_data1,
    input  logic [DATA_W-1:0]      rf_rd_data2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FIELD_W-1:0]     opcode,
    output logic [DATA_W-1:0]      operand1,
    output logic [DATA_W-1:0]      operand2,
    output logic [REG_ADDR_W-1:0]  dest_reg,
    output logic                   write_enable,
    output logic                   load_enable,
    output logic                   store_enable,
    output logic [MEM_ADDR_W-1:0]  mem_addr,
    output logic                   illegal_op,
    output logic [STALL_CNT_W-1:0] stall_count
);

    // Decoder outputs
    logic [FIELD_W-1:0]    dec_opcode;
    logic [REG_ADDR_W-1:0] dec_rs1;
    logic [REG_ADDR_W-1:0] dec_rs2;
    logic                  dec_use_rs1;
    logic                  dec_use_rs2;
    logic [DATA_W-1:0]     dec_op1;
    logic [DATA_W-1:0]     dec_op2;
    logic [REG_ADDR_W-1:0] dec_dest;
    logic [MEM_ADDR_W-1:0] dec_mem_addr;
    logic                  dec_we;
    logic                  dec_ld;
    logic                  dec_st;
    logic                  dec_illegal;

    // ID/EX register
    logic                   out_valid_q,   out_valid_d;
    logic [FIELD_W-1:0]     opcode_q,      opcode_d;
    logic [DATA_W-1:0]      operand1_q,    operand1_d;
    logic [DATA_W-1:0]      operand2_q,    operand2_d;
    logic [REG_ADDR_W-1:0]  dest_reg_q,    dest_reg_d;
    logic                   we_q,          we_d;
    logic                   ld_q,          ld_d;
    logic                   st_q,          st_d;
    logic [MEM_ADDR_W-1:0]  mem_addr_q,    mem_addr_d;
    logic                   illegal_q,     illegal_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    logic src_match;
    logic hazard;
    logic accept;

    instr_decoder #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .MEM_ADDR_W (MEM_ADDR_W)
    ) u_instr_decoder (
        .instruction (instruction),
        .rd1         (rf_rd_data1),
        .rd2         (rf_rd_data2),
        .opcode      (dec_opcode),
        .rs1_addr    (dec_rs1),
        .rs2_addr    (dec_rs2),
        .use_rs1     (dec_use_rs1),
        .use_rs2     (dec_use_rs2),
        .op1         (dec_op1),
        .op2         (dec_op2),
        .dest        (dec_dest),
        .mem_addr    (dec_mem_addr),
        .we          (dec_we),
        .ld          (dec_ld),
        .st          (dec_st),
        .illegal     (dec_illegal)
    );

    assign rf_rd_addr1 = dec_rs1;
    assign rf_rd_addr2 = dec_rs2;

    // Load-use detection against the instruction held in ID/EX
    always_comb begin
        src_match = (dec_use_rs1 && (dest_reg_q == dec_rs1)) ||
                    (dec_use_rs2 && (dest_reg_q == dec_rs2));
        hazard    = HAZARD_EN && out_valid_q && ld_q && in_valid && src_match;
        in_ready  = !reset && (!out_valid_q || out_ready) && !hazard;
        accept    = in_valid && in_ready;
    end

    // ID/EX next state: flush > accept > drain (bubble) > hold
    always_comb begin
        out_valid_d = out_valid_q;
        opcode_d    = opcode_q;
        operand1_d  = operand1_q;
        operand2_d  = operand2_q;
        dest_reg_d  = dest_reg_q;
        we_d        = we_q;
        ld_d        = ld_q;
        st_d        = st_q;
        mem_addr_d  = mem_addr_q;
        illegal_d   = illegal_q;
        if (flush) begin
            // Enables cleared too so a killed LD can never look like a pending load
            out_valid_d = 1'b0;
            we_d        = 1'b0;
            ld_d        = 1'b0;
            st_d        = 1'b0;
            illegal_d   = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            opcode_d    = dec_opcode;
            operand1_d  = dec_op1;
            operand2_d  = dec_op2;
            dest_reg_d  = dec_dest;
            we_d        = dec_we;
            ld_d        = dec_ld;
            st_d        = dec_st;
            mem_addr_d  = dec_mem_addr;
            illegal_d   = dec_illegal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            we_d        = 1'b0;
            ld_d        = 1'b0;
            st_d        = 1'b0;
            illegal_d   = 1'b0;
        end
    end

    // Saturating count of hazard-stall cycles
    always_comb begin
        stall_count_d = stall_count_q;
        if (hazard && !flush && (stall_count_q != {STALL_CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            opcode_q      <= '0;
            operand1_q    <= '0;
            operand2_q    <= '0;
            dest_reg_q    <= '0;
            we_q          <= 1'b0;
            ld_q          <= 1'b0;
            st_q          <= 1'b0;
            mem_addr_q    <= '0;
            illegal_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            opcode_q      <= opcode_d;
            operand1_q    <= operand1_d;
            operand2_q    <= operand2_d;
            dest_reg_q    <= dest_reg_d;
            we_q          <= we_d;
            ld_q          <= ld_d;
            st_q          <= st_d;
            mem_addr_q    <= mem_addr_d;
            illegal_q     <= illegal_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign opcode       = opcode_q;
    assign operand1     = operand1_q;
    assign operand2     = operand2_q;
    assign dest_reg     = dest_reg_q;
    assign write_enable = we_q;
    assign load_enable  = ld_q;
    assign store_enable = st_q;
    assign mem_addr     = mem_addr_q;
    assign illegal_op   = illegal_q;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Directed bench for pipelined_decode_stage with hand-computed expectations.
module tb_pipelined_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instruction;
    logic        flush;
    logic [3:0]  rf_rd_addr1;
    logic [3:0]  rf_rd_addr2;
    logic [15:0] rf_rd_data1;
    logic [15:0] rf_rd_data2;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  opcode;
    logic [15:0] operand1;
    logic [15:0] operand2;
    logic [3:0]  dest_reg;
    logic        write_enable;
    logic        load_enable;
    logic        store_enable;
    logic [3:0]  mem_addr;
    logic        illegal_op;
    logic [7:0]  stall_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipelined_decode_stage dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instruction  (instruction),
        .flush        (flush),
        .rf_rd_addr1  (rf_rd_addr1),
        .rf_rd_addr2  (rf_rd_addr2),
        .rf_rd_data1  (rf_rd_data1),
        .rf_rd_data2  (rf_rd_data2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .opcode       (opcode),
        .operand1     (operand1),
        .operand2     (operand2),
        .dest_reg     (dest_reg),
        .write_enable (write_enable),
        .load_enable  (load_enable),
        .store_enable (store_enable),
        .mem_addr     (mem_addr),
        .illegal_op   (illegal_op),
        .stall_count  (stall_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        instruction = 16'h0000;
        flush       = 1'b0;
        out_ready   = 1'b0;
        rf_rd_data1 = 16'h0000;
        rf_rd_data2 = 16'h0000;
        tick();
        tick();
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_stall_count", stall_count, 0);
        check_eq("rst_write_enable", write_enable, 0);
        check_eq("rst_opcode", opcode, 0);
        reset = 1'b0;

        // ADD r4 = r1 + r2
        instruction = 16'h1124; in_valid = 1'b1; rf_rd_data1 = 16'd5; rf_rd_data2 = 16'd7;
        out_ready = 1'b1;
        #1;
        check_eq("add_rf_addr1", rf_rd_addr1, 1);
        check_eq("add_rf_addr2", rf_rd_addr2, 2);
        check_eq("add_in_ready", in_ready, 1);
        tick();
        check_eq("add_out_valid", out_valid, 1);
        check_eq("add_opcode", opcode, 1);
        check_eq("add_operand1", operand1, 5);
        check_eq("add_operand2", operand2, 7);
        check_eq("add_dest", dest_reg, 4);
        check_eq("add_we", write_enable, 1);
        check_eq("add_ld", load_enable, 0);

        // LD r3 <- [9], then dependent ADD r4 = r3 + r1
        instruction = 16'h5309;
        tick();
        check_eq("ld_out_valid", out_valid, 1);
        check_eq("ld_load_enable", load_enable, 1);
        check_eq("ld_we", write_enable, 1);
        check_eq("ld_dest", dest_reg, 3);
        check_eq("ld_mem_addr", mem_addr, 9);
        instruction = 16'h1314; rf_rd_data1 = 16'h0033; rf_rd_data2 = 16'h0011;
        #1;
        check_eq("luse_in_ready_stall", in_ready, 0);
        tick();
        check_eq("luse_bubble_valid", out_valid, 0);
        check_eq("luse_bubble_ld", load_enable, 0);
        check_eq("luse_stall_count", stall_count, 1);
        check_eq("luse_in_ready_after", in_ready, 1);
        tick();
        check_eq("luse_add_valid", out_valid, 1);
        check_eq("luse_add_opcode", opcode, 1);
        check_eq("luse_add_dest", dest_reg, 4);
        check_eq("luse_stall_count_hold", stall_count, 1);

        // SUB r3 = r5 - r6, then back-pressure for three cycles
        instruction = 16'h2563; rf_rd_data1 = 16'h0011; rf_rd_data2 = 16'h0022;
        tick();
        check_eq("sub_opcode", opcode, 2);
        check_eq("sub_operand1", operand1, 16'h0011);
        check_eq("sub_operand2", operand2, 16'h0022);
        check_eq("sub_dest", dest_reg, 3);
        out_ready = 1'b0; instruction = 16'h3705; rf_rd_data1 = 16'h0099;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("hold_in_ready", in_ready, 0);
            tick();
            check_eq("hold_out_valid", out_valid, 1);
            check_eq("hold_opcode", opcode, 2);
            check_eq("hold_operand1", operand1, 16'h0011);
        end
        out_ready = 1'b1;
        #1;
        check_eq("release_in_ready", in_ready, 1);
        tick();
        check_eq("ldi_opcode", opcode, 3);
        check_eq("ldi_dest", dest_reg, 7);
        check_eq("ldi_operand1", operand1, 5);
        check_eq("ldi_operand2", operand2, 0);
        check_eq("ldi_we", write_enable, 1);

        // Flush with a held LDI and an incoming ST
        instruction = 16'h7123; flush = 1'b1; out_ready = 1'b0;
        tick();
        check_eq("flush_out_valid", out_valid, 0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check_eq("flush_drop_valid", out_valid, 0);
        check_eq("flush_drop_st", store_enable, 0);

        // Illegal opcode, STI, ST
        in_valid = 1'b1; out_ready = 1'b1; instruction = 16'hF123;
        tick();
        check_eq("ill_valid", out_valid, 1);
        check_eq("ill_flag", illegal_op, 1);
        check_eq("ill_en", {write_enable, load_enable, store_enable}, 0);
        instruction = 16'h4A03;
        tick();
        check_eq("sti_operand1", operand1, 16'h000A);
        check_eq("sti_mem_addr", mem_addr, 3);
        check_eq("sti_st", store_enable, 1);
        check_eq("sti_we", write_enable, 0);
        check_eq("sti_illegal", illegal_op, 0);
        instruction = 16'h7125; rf_rd_data1 = 16'h0055;
        tick();
        check_eq("st_opcode", opcode, 7);
        check_eq("st_operand1", operand1, 16'h0055);
        check_eq("st_mem_addr", mem_addr, 5);
        check_eq("st_st", store_enable, 1);

        // rs1 == rs2 == dest of pending LD stalls exactly once
        instruction = 16'h5409;
        tick();
        instruction = 16'h1444;
        tick();
        check_eq("same_bubble_valid", out_valid, 0);
        check_eq("same_stall_count", stall_count, 2);
        tick();
        check_eq("same_add_valid", out_valid, 1);
        check_eq("same_add_opcode", opcode, 1);
        check_eq("same_stall_count2", stall_count, 2);

        // Persistent hazard under back-pressure: saturation at 255
        instruction = 16'h5209;
        tick();
        out_ready = 1'b0; instruction = 16'h1224;
        for (int i = 0; i < 10; i++) tick();
        check_eq("sat_partial", stall_count, 12);
        check_eq("sat_hold_ld", load_enable, 1);
        for (int i = 0; i < 250; i++) tick();
        check_eq("sat_count", stall_count, 255);
        check_eq("sat_in_ready", in_ready, 0);

        // Reset mid-stall clears everything
        reset = 1'b1;
        #1;
        check_eq("rst_mid_in_ready", in_ready, 0);
        tick();
        check_eq("rst_mid_count", stall_count, 0);
        check_eq("rst_mid_valid", out_valid, 0);
        check_eq("rst_mid_ld", load_enable, 0);
        reset = 1'b0;

        // A flushed hazard cycle is not counted
        out_ready = 1'b1; instruction = 16'h5109;
        tick();
        instruction = 16'h1114; flush = 1'b1; out_ready = 1'b0;
        tick();
        check_eq("flush_hz_valid", out_valid, 0);
        check_eq("flush_hz_count", stall_count, 0);
        flush = 1'b0; in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
